mem_port_arbiter: RTL

- Shares one single-port synchronous-read RAM (1-cycle read latency) between the CPU's instruction-fetch requester (IF) and its load/store requester (DM).
- Sits between the pipeline front/back ends and the unified BIOS/data RAM. It generates per-requester ready, which the pipeline uses as its stall signal, and routes read data back to the requester that issued the read.
- Data accesses have priority. A starvation guard guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 63 ++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sync-read RAM between fetch (IF) and load/store (DM) ports.
// Data wins conflicts unless fetch has been starved for STARVE_LIMIT cycles.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_resp_valid,
  output logic [DATA_WIDTH-1:0] if_resp_data,
  input  logic                  dm_req_valid,
  input  logic [ADDR_WIDTH-1:0] dm_req_addr,
  input  logic [3:0]            dm_req_we,
  input  logic [DATA_WIDTH-1:0] dm_req_wdata,
  output logic                  dm_req_ready,
  output logic                  dm_resp_valid,
  output logic [DATA_WIDTH-1:0] dm_resp_data,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [15:0]           conflict_count
);
  typedef enum logic [1:0] {NONE, IF_RD, DM_RD} owner_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  owner_t owner, owner_nx;
  logic [3:0] starve_cnt;
  logic if_wins, if_hs, dm_hs;
  always_comb begin
    if_wins      = dm_req_valid & if_req_valid & (starve_cnt == LIMIT);
    dm_req_ready = ~rst & dm_req_valid & ~if_wins;
    if_req_ready = ~rst & if_req_valid & (~dm_req_valid | if_wins);
    if_hs        = if_req_valid & if_req_ready;
    dm_hs        = dm_req_valid & dm_req_ready;
    mem_en       = if_hs | dm_hs;
    mem_we       = dm_hs ? dm_req_we : 4'd0;
    mem_addr     = if_hs ? if_req_addr : dm_hs ? dm_req_addr : '0;
    mem_din      = dm_hs ? dm_req_wdata : '0;
    owner_nx     = if_hs ? IF_RD : (dm_hs && dm_req_we == 4'd0) ? DM_RD : NONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner          <= NONE;
      starve_cnt     <= 4'd0;
      conflict_count <= 16'd0;
    end else begin
      owner          <= owner_nx;
      starve_cnt     <= (~if_req_valid | if_hs) ? 4'd0 : (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
      if (if_req_valid & dm_req_valid & ~&conflict_count)
        conflict_count <= conflict_count + 16'd1;
    end
  end
  // Response routing follows the owner of last cycle's read; reset drops it at once.
  assign if_resp_valid = (owner == IF_RD);
  assign dm_resp_valid = (owner == DM_RD);
  assign if_resp_data  = if_resp_valid ? mem_dout : '0;
  assign dm_resp_data  = dm_resp_valid ? mem_dout : '0;
endmodule
